// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the LCD instruction display.
//   - CPU opcode encoding (LOAD .. DISPLAY)
//   - HD44780 command bytes used by init and refresh
//   - top-level FSM state and per-write phase enums
//   - mnemonic_char(): ASCII for one of the 5 mnemonic positions
package lcd_pkg;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_CONVERT,
    ST_WRITE
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_EN,
    PH_WAIT
  } phase_t;

  function automatic logic [7:0] mnemonic_char(input logic [2:0] op, input logic [2:0] pos);
    logic [39:0] s;
    logic [7:0]  c;
    case (op)
      OP_LOAD:  s = "LOAD ";
      OP_ADD:   s = "ADD  ";
      OP_ADDI:  s = "ADDI ";
      OP_SUB:   s = "SUB  ";
      OP_SUBI:  s = "SUBI ";
      OP_MUL:   s = "MUL  ";
      OP_CLEAR: s = "CLEAR";
      default:  s = "DISP ";
    endcase
    case (pos)
      3'd0:    c = s[39:32];
      3'd1:    c = s[31:24];
      3'd2:    c = s[23:16];
      3'd3:    c = s[15:8];
      default: c = s[7:0];
    endcase
    return c;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = CMD_FUNC_SET;
      2'd1:    c = CMD_DISP_ON;
      2'd2:    c = CMD_ENTRY;
      default: c = CMD_CLEAR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, 16-bit binary to five BCD digits.
//   clk, reset_n : clock, async active-low reset
//   go           : one-cycle strobe, samples bin
//   bin[15:0]    : magnitude to convert
//   bcd[19:0]    : digits, [19:16] = ten-thousands ... [3:0] = units
//   done         : one-cycle pulse 16 cycles after go (17 cycles inclusive);
//                  bcd is valid from that cycle on until the next go
// The first shift is folded into the load (all digits are zero then, so no
// add-3 correction applies), leaving 15 shift cycles after go.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        done
);

  logic [19:0] bcd_q, bcd_d;
  logic [15:0] sh_q, sh_d;
  logic [3:0]  rem_q, rem_d;
  logic        run_q, run_d;
  logic        done_q, done_d;
  logic [15:0] adj;

  // Before the final shift the value held is at most 32767, so the top digit
  // never reaches 5 and only the low four digits need the add-3 correction.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                         : bcd_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    bcd_d  = bcd_q;
    sh_d   = sh_q;
    rem_d  = rem_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (go) begin
      bcd_d = {19'd0, bin[15]};
      sh_d  = {bin[14:0], 1'b0};
      rem_d = 4'd15;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {bcd_q[18:16], adj, sh_q[15]};
      sh_d  = {sh_q[14:0], 1'b0};
      rem_d = rem_q - 4'd1;
      if (rem_q == 4'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_q  <= '0;
      sh_q   <= '0;
      rem_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      sh_q   <= sh_d;
      rem_q  <= rem_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: rtl/lcd_instr_display.sv
// lcd_instr_display: drives a 16x2 HD44780 LCD (8-bit, write-only) showing
// the last instruction accepted from the CPU sequencer.
//   clk, reset_n            : clock, async active-low reset
//   start, opcode, reg_idx,
//   value                   : one-cycle request and its fields
//   busy                    : high during init/refresh or with a request pending
//   lcd_data, lcd_rs, lcd_rw,
//   lcd_en, lcd_on, lcd_blon: LCD pins
// Build option: define LCD_SIGNED_EN to show value as two's complement
// ('+'/'-' and magnitude); otherwise unsigned with a blank sign position.
module lcd_instr_display
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC = 750000,
  parameter int unsigned EN_CYC    = 16,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned CMD_CYC   = 2500,
  parameter int unsigned CLR_CYC   = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  opcode,
  input  logic [3:0]  reg_idx,
  input  logic [15:0] value,
  output logic        busy,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        lcd_blon
);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [5:0]  widx_q, widx_d;     // write index within INIT (0..3) or refresh (0..33)
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;         // fields of the request being displayed
  logic [3:0]  reg_q, reg_d;
  logic [15:0] val_q, val_d;
  logic        pend_q, pend_d;     // single last-wins pending slot
  logic [2:0]  pop_q, pop_d;
  logic [3:0]  preg_q, preg_d;
  logic [15:0] pval_q, pval_d;
  logic        go_q, go_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;

  logic [31:0] wait_len;
  logic [5:0]  last_idx;
  logic        finish;
  logic [15:0] mag;
  logic [7:0]  sign_ch;
  logic [19:0] bcd;
  logic        bcd_done;

`ifdef LCD_SIGNED_EN
  assign mag     = val_q[15] ? (~val_q + 16'd1) : val_q;
  assign sign_ch = val_q[15] ? 8'h2D : 8'h2B;
`else
  assign mag     = val_q;
  assign sign_ch = CH_SPACE;
`endif

  bin2bcd_seq u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (go_q),
    .bin     (mag),
    .bcd     (bcd),
    .done    (bcd_done)
  );

  assign wait_len = (state_q == ST_INIT && widx_q == 6'd3) ? CLR_CYC : CMD_CYC;
  assign last_idx = (state_q == ST_INIT) ? 6'd3 : 6'd33;

  // Main sequencer, write-phase engine and request capture.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    reg_d   = reg_q;
    val_d   = val_q;
    pend_d  = pend_q;
    pop_d   = pop_q;
    preg_d  = preg_q;
    pval_d  = pval_q;
    finish  = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PWRUP_CYC - 1) begin
          state_d = ST_INIT;
          widx_d  = '0;
          phase_d = PH_SETUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_INIT, ST_WRITE: begin
        cnt_d = cnt_q + 32'd1;
        case (phase_q)
          PH_SETUP: if (cnt_q == SETUP_CYC - 1) begin
            phase_d = PH_EN;
            cnt_d   = '0;
          end
          PH_EN: if (cnt_q == EN_CYC - 1) begin
            phase_d = PH_WAIT;
            cnt_d   = '0;
          end
          default: if (cnt_q == wait_len - 1) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            if (widx_q == last_idx) finish = 1'b1;
            else                    widx_d = widx_q + 6'd1;
          end
        endcase
      end
      ST_IDLE: begin
        if (start) begin
          op_d    = opcode;
          reg_d   = reg_idx;
          val_d   = value;
          pend_d  = 1'b0;
          state_d = ST_CONVERT;
        end else if (pend_q) begin
          op_d    = pop_q;
          reg_d   = preg_q;
          val_d   = pval_q;
          pend_d  = 1'b0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (bcd_done) begin
          state_d = ST_WRITE;
          widx_d  = '0;
          phase_d = PH_SETUP;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_PWRUP;
    endcase

    // End of init or refresh: a pending request skips IDLE entirely.
    if (finish) begin
      if (pend_q) begin
        op_d    = pop_q;
        reg_d   = preg_q;
        val_d   = pval_q;
        pend_d  = 1'b0;
        state_d = ST_CONVERT;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Requests arriving outside IDLE land in the pending slot; this wins over
    // a same-cycle consume so the newer request is not lost.
    if (start && state_q != ST_IDLE) begin
      pend_d = 1'b1;
      pop_d  = opcode;
      preg_d = reg_idx;
      pval_d = value;
    end
  end

  assign go_d = (state_d == ST_CONVERT) && (state_q != ST_CONVERT);

  // Byte for the write selected by the next state/index; registered so RS and
  // DATA change only when a write's SETUP phase begins.
  always_comb begin
    logic [3:0] pos;
    logic [3:0] ones;
    rs_d   = rs_q;
    data_d = data_q;
    pos    = '0;
    ones   = (reg_q >= 4'd10) ? reg_q - 4'd10 : reg_q;
    if (state_d == ST_INIT) begin
      rs_d   = 1'b0;
      data_d = init_cmd(widx_d[1:0]);
    end else if (state_d == ST_WRITE) begin
      rs_d = 1'b1;
      if (widx_d == 6'd0) begin
        rs_d   = 1'b0;
        data_d = CMD_LINE1;
      end else if (widx_d == 6'd17) begin
        rs_d   = 1'b0;
        data_d = CMD_LINE2;
      end else if (widx_d < 6'd17) begin
        pos = widx_d[3:0] - 4'd1;
        if (pos < 4'd5)                          data_d = mnemonic_char(op_q, pos[2:0]);
        else if (op_q == OP_CLEAR)               data_d = CH_SPACE;
        else if (pos == 4'd6)                    data_d = 8'h52;  // 'R'
        else if (pos == 4'd7)                    data_d = (reg_q >= 4'd10) ? 8'h31 : CH_ZERO;
        else if (pos == 4'd8)                    data_d = CH_ZERO + {4'd0, ones};
        else                                     data_d = CH_SPACE;
      end else begin
        pos = widx_d[3:0] - 4'd2;
        data_d = CH_SPACE;
        if (op_q != OP_CLEAR) begin
          case (pos)
            4'd0:    data_d = 8'h56;  // 'V'
            4'd1:    data_d = 8'h41;  // 'A'
            4'd2:    data_d = 8'h4C;  // 'L'
            4'd4:    data_d = sign_ch;
            4'd5:    data_d = CH_ZERO + {4'd0, bcd[19:16]};
            4'd6:    data_d = CH_ZERO + {4'd0, bcd[15:12]};
            4'd7:    data_d = CH_ZERO + {4'd0, bcd[11:8]};
            4'd8:    data_d = CH_ZERO + {4'd0, bcd[7:4]};
            4'd9:    data_d = CH_ZERO + {4'd0, bcd[3:0]};
            default: data_d = CH_SPACE;
          endcase
        end
      end
    end
  end

  assign en_d = (state_d == ST_INIT || state_d == ST_WRITE) && (phase_d == PH_EN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PWRUP;
      phase_q <= PH_SETUP;
      widx_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      reg_q   <= '0;
      val_q   <= '0;
      pend_q  <= 1'b0;
      pop_q   <= '0;
      preg_q  <= '0;
      pval_q  <= '0;
      go_q    <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      pend_q  <= pend_d;
      pop_q   <= pop_d;
      preg_q  <= preg_d;
      pval_q  <= pval_d;
      go_q    <= go_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
    end
  end

  assign busy     = (state_q != ST_IDLE) || pend_q;
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_en   = en_q;
  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b1;

endmodule

// File: tb/tb_lcd_instr_display.sv
// Bench for lcd_instr_display with short timing parameters. A monitor decodes
// every lcd_en pulse and compares it with a queue of expected writes built
// from formatted strings; literal line texts pin the formatter.
module tb_lcd_instr_display;

  localparam int unsigned PW = 20, ENC = 2, SU = 1, CM = 5, CL = 10;
  localparam int INIT_LEN = PW + 3 * (SU + ENC + CM) + (SU + ENC + CL);
  localparam int REF_LEN  = 17 + 34 * (SU + ENC + CM);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  opcode = '0;
  logic [3:0]  reg_idx = '0;
  logic [15:0] value = '0;
  logic        busy, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
  logic [7:0]  lcd_data;

  lcd_instr_display #(
    .PWRUP_CYC(PW), .EN_CYC(ENC), .SETUP_CYC(SU), .CMD_CYC(CM), .CLR_CYC(CL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .reg_idx(reg_idx), .value(value), .busy(busy), .lcd_data(lcd_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on),
    .lcd_blon(lcd_blon)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0, pulses = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_q[$];
  logic [7:0] l1[16], l2[16];
  int lsel = 0, lpos = 0;
  logic       en_prev = 1'b0;
  logic [8:0] prev_bus = '0;
  int         en_w = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, expv);
    end
  endtask

  // Reference formatter for one display line.
  function automatic string exp_line(input logic [2:0] op, input logic [3:0] r,
                                     input logic [15:0] v, input int which);
    string m, sg;
    int    mag;
    case (op)
      3'd0: m = "LOAD ";
      3'd1: m = "ADD  ";
      3'd2: m = "ADDI ";
      3'd3: m = "SUB  ";
      3'd4: m = "SUBI ";
      3'd5: m = "MUL  ";
      3'd6: m = "CLEAR";
      default: m = "DISP ";
    endcase
    if (op == 3'd6) begin
      if (which == 1) return "CLEAR           ";
      return "                ";
    end
`ifdef LCD_SIGNED_EN
    if (v[15]) begin sg = "-"; mag = 65536 - int'(v); end
    else       begin sg = "+"; mag = int'(v); end
`else
    sg = " ";
    mag = int'(v);
`endif
    if (which == 1) return $sformatf("%s R%02d       ", m, int'(r));
    return $sformatf("VAL %s%05d      ", sg, mag);
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_refresh(input logic [2:0] op, input logic [3:0] r, input logic [15:0] v);
    string a, b;
    logic [7:0] c;
    a = exp_line(op, r, v, 1);
    b = exp_line(op, r, v, 2);
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) begin c = a[i]; exp_q.push_back({1'b1, c}); end
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) begin c = b[i]; exp_q.push_back({1'b1, c}); end
  endtask

  function automatic string line_str(input int which);
    string s = "";
    for (int i = 0; i < 16; i++) s = $sformatf("%s%c", s, (which == 1) ? l1[i] : l2[i]);
    return s;
  endfunction

  // Per-cycle monitor/compare process.
  always @(negedge clk) begin
    logic [8:0] bus, e;
    bus = {lcd_rs, lcd_data};
    if (!reset_n) begin
      en_prev = 1'b0;
      en_w = 0;
      lsel = 0;
    end else begin
      chk("static_pins", {29'd0, lcd_rw, lcd_on, lcd_blon}, 32'd3);
      if (lcd_en) begin
        if (!en_prev) chk("setup_before_en", {23'd0, bus}, {23'd0, prev_bus});
        else          chk("bus_stable_en",   {23'd0, bus}, {23'd0, prev_bus});
        en_w++;
      end else if (en_prev) begin
        chk("en_width", en_w, ENC);
        en_w = 0;
        pulses++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_pulse: got rs=%0b data=%02h expected no write", lcd_rs, lcd_data);
        end else begin
          e = exp_q.pop_front();
          chk("lcd_write", {23'd0, bus}, {23'd0, e});
        end
        if (!lcd_rs && lcd_data == 8'h80) begin lsel = 1; lpos = 0; end
        else if (!lcd_rs && lcd_data == 8'hC0) begin lsel = 2; lpos = 0; end
        else if (lcd_rs && lpos < 16) begin
          if (lsel == 1) l1[lpos] = lcd_data;
          else if (lsel == 2) l2[lpos] = lcd_data;
          lpos++;
        end
      end
      prev_bus = bus;
      en_prev = lcd_en;
    end
  end

  task automatic wait_idle(input int maxc, input int t0, input int expd, input string name);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (busy && n < maxc);
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL %s: got busy still high after %0d cycles expected idle", name, n);
    end else chk(name, cyc - t0, expd);
  endtask

  task automatic req(input logic [2:0] op, input logic [3:0] r, input logic [15:0] v, output int t0);
    @(negedge clk);
    start = 1'b1; opcode = op; reg_idx = r; value = v;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_refresh(input logic [2:0] op, input logic [3:0] r, input logic [15:0] v,
                             input string e1, input string e2s, input string e2u);
    int t0, p0;
    push_refresh(op, r, v);
    p0 = pulses;
    req(op, r, v, t0);
    wait_idle(600, t0, REF_LEN, "refresh_len");
    chk("refresh_pulses", pulses - p0, 34);
    chk_str("line1", line_str(1), e1);
`ifdef LCD_SIGNED_EN
    chk_str("line2", line_str(2), e2s);
`else
    chk_str("line2", line_str(2), e2u);
`endif
  endtask

  initial begin
    int t0, p0;
    logic found;
    // Reset state
    #12;
    chk("rst_data", {24'd0, lcd_data}, 32'h00);
    chk("rst_ctl", {28'd0, lcd_rs, lcd_rw, lcd_en, busy}, 32'h1);
    chk("rst_pwr", {30'd0, lcd_on, lcd_blon}, 32'h3);
    push_init();
    @(negedge clk); reset_n = 1'b1; t0 = cyc;
    wait_idle(200, t0, INIT_LEN, "init_len");
    chk("init_pulses", pulses, 4);

    run_refresh(3'd0, 4'd3,  16'hFFFB, "LOAD  R03       ", "VAL -00005      ", "VAL  65531      ");
    run_refresh(3'd1, 4'd15, 16'd1234, "ADD   R15       ", "VAL +01234      ", "VAL  01234      ");
    run_refresh(3'd6, 4'd2,  16'd99,   "CLEAR           ", "                ", "                ");
    run_refresh(3'd7, 4'd10, 16'h8000, "DISP  R10       ", "VAL -32768      ", "VAL  32768      ");
    run_refresh(3'd5, 4'd9,  16'hFFFF, "MUL   R09       ", "VAL -00001      ", "VAL  65535      ");
    run_refresh(3'd0, 4'd0,  16'd0,    "LOAD  R00       ", "VAL +00000      ", "VAL  00000      ");

    // Back-to-back: second and third request land during the first refresh.
    push_refresh(3'd0, 4'd1, 16'd1);
    push_refresh(3'd0, 4'd1, 16'd3);
    p0 = pulses;
    req(3'd0, 4'd1, 16'd1, t0);
    begin
      int tx;
      repeat (30) @(posedge clk);
      req(3'd0, 4'd1, 16'd2, tx);
      repeat (50) @(posedge clk);
      req(3'd0, 4'd1, 16'd3, tx);
    end
    wait_idle(1200, t0, 2 * REF_LEN, "b2b_len");
    chk("b2b_pulses", pulses - p0, 68);
`ifdef LCD_SIGNED_EN
    chk_str("b2b_line2", line_str(2), "VAL +00003      ");
`else
    chk_str("b2b_line2", line_str(2), "VAL  00003      ");
`endif

    // Reset during line-2 writes.
    push_refresh(3'd2, 4'd7, 16'd42);
    p0 = pulses;
    req(3'd2, 4'd7, 16'd42, t0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (pulses - p0 >= 20 && lcd_en) found = 1'b1;
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL line2_en_search: got no line-2 enable expected one within 400 cycles");
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_en_data", {23'd0, lcd_en, lcd_data}, 32'h0);
    chk("midrst_rs_busy", {30'd0, lcd_rs, busy}, 32'h1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_init();
    reset_n = 1'b1; t0 = cyc;
    wait_idle(200, t0, INIT_LEN, "reinit_len");
    p0 = pulses;
    repeat (100) @(posedge clk);
    #1;
    chk("no_refresh_pulses", pulses - p0, 0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
